// File: rtl/cache_pkg.sv
// cache_pkg: types and constants shared by the cache-side sequencers.
//   arb_state_t : port arbiter FSM states
//   ARB_REQ0/1  : requester ids (0 = instruction fetch, 1 = data load/store)
package cache_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

   localparam logic ARB_REQ0 = 1'b0;
   localparam logic ARB_REQ1 = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: 8-bit up-counter guarding a wait on an external responder.
//   clk     in  clock, rising edge
//   reset   in  asynchronous active-low reset
//   clear   in  synchronous clear (wins over en)
//   en      in  count enable
//   expired out count == TIMEOUT
module arb_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares the cache controller CPU port between two
// requesters (0 = ifetch, 1 = data) with round-robin grant, one transaction
// in flight and a watchdog against a hung controller.
//   clk, reset                 clock, async active-low reset
//   reqN/rwN/addrN/wdataN      requester N request (held until rdyN/errN)
//   rdyN / errN                requester N completion / timeout pulse
//   rdata                      read data, valid from rdy, held until next completion
//   Strobe                     one-cycle request pulse to the controller
//   DRW / DAddr / DDataOut     registered command to the controller, held
//   DDataIn / DReady           controller read data / completion
module cache_port_arbiter
   import cache_pkg::*;
#(
   parameter int unsigned AW      = 16,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          rw0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          rdy0,
   output logic          err0,
   input  logic          req1,
   input  logic          rw1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          rdy1,
   output logic          err1,
   output logic [DW-1:0] rdata,
   output logic          Strobe,
   output logic          DRW,
   output logic [AW-1:0] DAddr,
   output logic [DW-1:0] DDataOut,
   input  logic [DW-1:0] DDataIn,
   input  logic          DReady
);

   arb_state_t state, state_nxt;
   logic       owner;
   logic       ptr;
   logic       err_flag;
   logic       grant;
   logic       wd_clear;
   logic       wd_en;
   logic       wd_expired;

   arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ARB_IDLE;
         owner    <= ARB_REQ0;
         ptr      <= ARB_REQ0;
         err_flag <= 1'b0;
         DRW      <= 1'b0;
         DAddr    <= '0;
         DDataOut <= '0;
         rdata    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ARB_IDLE: begin
               if (req0 || req1) begin
                  owner    <= grant;
                  err_flag <= 1'b0;
                  DRW      <= (grant == ARB_REQ1) ? rw1    : rw0;
                  DAddr    <= (grant == ARB_REQ1) ? addr1  : addr0;
                  DDataOut <= (grant == ARB_REQ1) ? wdata1 : wdata0;
               end
            end
            ARB_WAIT: begin
               // DReady takes priority over an expiring watchdog.
               if (DReady) begin
                  if (!DRW) begin
                     rdata <= DDataIn;
                  end
               end else if (wd_expired) begin
                  err_flag <= 1'b1;
               end
            end
            ARB_DONE: begin
               ptr <= ~owner;
            end
            default: ;
         endcase
      end
   end

   // Next state and round-robin grant.
   always_comb begin
      grant     = ARB_REQ0;
      state_nxt = ARB_IDLE;
      if (ptr == ARB_REQ0) begin
         grant = req0 ? ARB_REQ0 : ARB_REQ1;
      end else begin
         grant = req1 ? ARB_REQ1 : ARB_REQ0;
      end
      case (state)
         ARB_IDLE:  state_nxt = (req0 || req1) ? ARB_ISSUE : ARB_IDLE;
         ARB_ISSUE: state_nxt = ARB_WAIT;
         ARB_WAIT:  state_nxt = (DReady || wd_expired) ? ARB_DONE : ARB_WAIT;
         ARB_DONE:  state_nxt = ARB_IDLE;
         default:   state_nxt = ARB_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      Strobe   = 1'b0;
      rdy0     = 1'b0;
      rdy1     = 1'b0;
      err0     = 1'b0;
      err1     = 1'b0;
      wd_clear = 1'b0;
      wd_en    = 1'b0;
      case (state)
         ARB_ISSUE: begin
            Strobe   = 1'b1;
            wd_clear = 1'b1;
         end
         ARB_WAIT: begin
            wd_en = 1'b1;
         end
         ARB_DONE: begin
            rdy0 = !err_flag && (owner == ARB_REQ0);
            rdy1 = !err_flag && (owner == ARB_REQ1);
            err0 =  err_flag && (owner == ARB_REQ0);
            err1 =  err_flag && (owner == ARB_REQ1);
         end
         default: ;
      endcase
   end

endmodule
